// File: rtl/debounce_bank_amisha.sv
// Multi-channel switch debouncer: 2-FF synchroniser, per-channel down-counter FSM, level and edge ticks.
// Optional long-press detector compiled in with `define DEBOUNCE_LONGPRESS_EN.
module debounce_bank_amisha #(
    parameter int CH_AMISHA = 4,
    parameter int N_AMISHA  = 21,
    parameter int L_AMISHA  = 24
) (
    input  logic                 clk_amisha,
    input  logic                 reset_amisha,
    input  logic                 ce_amisha,
    input  logic [CH_AMISHA-1:0] sw_amisha,
    output logic [CH_AMISHA-1:0] db_level_amisha,
    output logic [CH_AMISHA-1:0] rise_tick_amisha,
    output logic [CH_AMISHA-1:0] fall_tick_amisha,
    output logic [CH_AMISHA-1:0] long_tick_amisha
);

    typedef enum logic [1:0] {
        ST_ZERO  = 2'd0,
        ST_WAIT1 = 2'd1,
        ST_ONE   = 2'd2,
        ST_WAIT0 = 2'd3
    } state_t;

    localparam logic [N_AMISHA-1:0] CNT_ALL  = {N_AMISHA{1'b1}};
    localparam logic [N_AMISHA-1:0] CNT_ZERO = {N_AMISHA{1'b0}};
    localparam logic [N_AMISHA-1:0] CNT_ONE  = N_AMISHA'(1);

    logic [CH_AMISHA-1:0] sync1_q;
    logic [CH_AMISHA-1:0] sync2_q;

    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            sync1_q <= {CH_AMISHA{1'b0}};
            sync2_q <= {CH_AMISHA{1'b0}};
        end else begin
            sync1_q <= sw_amisha;
            sync2_q <= sync1_q;
        end
    end

    for (genvar gi = 0; gi < CH_AMISHA; gi++) begin : g_ch
        state_t              state_q, state_d;
        logic [N_AMISHA-1:0] cnt_q, cnt_d, cnt_dec;
        logic                level_q, rise_q, fall_q;
        logic                level_d, rise_d, fall_d;
        logic                s;

        assign s = sync2_q[gi];
        // Saturating decrement: the counter can never wrap below zero.
        assign cnt_dec = (cnt_q == CNT_ZERO) ? CNT_ZERO : (cnt_q - CNT_ONE);

        always_ff @(posedge clk_amisha or posedge reset_amisha) begin
            if (reset_amisha) begin
                state_q <= ST_ZERO;
                cnt_q   <= CNT_ZERO;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                ST_ZERO: begin
                    if (s) begin
                        state_d = ST_WAIT1;
                        cnt_d   = CNT_ALL;
                    end else begin
                        cnt_d = CNT_ZERO;
                    end
                end
                ST_WAIT1: begin
                    // Abort is checked every clock, independent of ce.
                    if (!s) begin
                        state_d = ST_ZERO;
                        cnt_d   = CNT_ZERO;
                    end else if (ce_amisha) begin
                        cnt_d = cnt_dec;
                        if (cnt_dec == CNT_ZERO) begin
                            state_d = ST_ONE;
                        end else begin
                            state_d = ST_WAIT1;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_ONE: begin
                    if (!s) begin
                        state_d = ST_WAIT0;
                        cnt_d   = CNT_ALL;
                    end else begin
                        cnt_d = CNT_ZERO;
                    end
                end
                ST_WAIT0: begin
                    if (s) begin
                        state_d = ST_ONE;
                        cnt_d   = CNT_ZERO;
                    end else if (ce_amisha) begin
                        cnt_d = cnt_dec;
                        if (cnt_dec == CNT_ZERO) begin
                            state_d = ST_ZERO;
                        end else begin
                            state_d = ST_WAIT0;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                default: begin
                    state_d = ST_ZERO;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end

        always_comb begin
            level_d = (state_d == ST_ONE) || (state_d == ST_WAIT0);
            rise_d  = level_d & ~level_q;
            fall_d  = ~level_d & level_q;
        end

        assign db_level_amisha[gi]  = level_q;
        assign rise_tick_amisha[gi] = rise_q;
        assign fall_tick_amisha[gi] = fall_q;

`ifdef DEBOUNCE_LONGPRESS_EN
        logic [L_AMISHA-1:0] lp_q, lp_d;
        logic                long_q, long_d;

        always_ff @(posedge clk_amisha or posedge reset_amisha) begin
            if (reset_amisha) begin
                lp_q   <= {L_AMISHA{1'b0}};
                long_q <= 1'b0;
            end else begin
                lp_q   <= lp_d;
                long_q <= long_d;
            end
        end

        // Counts ce-high cycles spent in ONE; the pulse fires only on the step into all-ones.
        always_comb begin
            if (state_q == ST_ONE) begin
                if (ce_amisha && (lp_q != {L_AMISHA{1'b1}})) begin
                    lp_d = lp_q + L_AMISHA'(1);
                end else begin
                    lp_d = lp_q;
                end
            end else begin
                lp_d = {L_AMISHA{1'b0}};
            end
            long_d = (lp_d == {L_AMISHA{1'b1}}) && (lp_q != {L_AMISHA{1'b1}});
        end

        assign long_tick_amisha[gi] = long_q;
`else
        // Tied low; L_AMISHA only sizes the compiled-out counter.
        assign long_tick_amisha[gi] = (L_AMISHA < 0);
`endif
    end

endmodule

// File: tb/tb_debounce_bank_amisha.sv
// Self-checking bench for debounce_bank_amisha: directed table, corner sequences, random run vs. model.
module tb_debounce_bank_amisha;

    localparam int CH     = 2;
    localparam int N      = 3;
    localparam int L      = 4;
    localparam int PERIOD = (1 << N) - 1;

    logic          clk_amisha   = 1'b0;
    logic          reset_amisha = 1'b0;
    logic          ce_amisha    = 1'b0;
    logic [CH-1:0] sw_amisha    = '0;
    logic [CH-1:0] db_level_amisha, rise_tick_amisha, fall_tick_amisha, long_tick_amisha;

    debounce_bank_amisha #(.CH_AMISHA(CH), .N_AMISHA(N), .L_AMISHA(L)) dut (
        .clk_amisha       (clk_amisha),
        .reset_amisha     (reset_amisha),
        .ce_amisha        (ce_amisha),
        .sw_amisha        (sw_amisha),
        .db_level_amisha  (db_level_amisha),
        .rise_tick_amisha (rise_tick_amisha),
        .fall_tick_amisha (fall_tick_amisha),
        .long_tick_amisha (long_tick_amisha)
    );

    always #5 clk_amisha = ~clk_amisha;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: raw samples pass through two stages, then the level flips once the
    // disagreeing sample has persisted for PERIOD ce-high cycles after the wait began.
    bit m_s1[CH], m_s2[CH], m_level[CH], m_pend[CH];
    int m_credit[CH];
`ifdef DEBOUNCE_LONGPRESS_EN
    localparam int LP_MAX = (1 << L) - 1;
    int m_lp[CH];
`endif
    logic [CH-1:0] e_level, e_rise, e_fall, e_long;

    typedef struct {
        logic [CH-1:0] sw;
        logic [CH-1:0] lvl;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
    } vec_t;
    vec_t tbl[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_level[i] = 0; m_pend[i] = 0; m_credit[i] = 0;
`ifdef DEBOUNCE_LONGPRESS_EN
            m_lp[i] = 0;
`endif
        end
        e_level = '0; e_rise = '0; e_fall = '0; e_long = '0;
    endtask

    task automatic model_edge(input logic [CH-1:0] sw, input logic ce);
        for (int i = 0; i < CH; i++) begin
            bit s, old;
            s   = m_s2[i];
            old = m_level[i];
            e_long[i] = 1'b0;
`ifdef DEBOUNCE_LONGPRESS_EN
            if (m_level[i] && !m_pend[i]) begin
                if (ce && m_lp[i] < LP_MAX) begin
                    m_lp[i]++;
                    if (m_lp[i] == LP_MAX) e_long[i] = 1'b1;
                end
            end else begin
                m_lp[i] = 0;
            end
`endif
            if (s != m_level[i]) begin
                if (!m_pend[i]) begin
                    m_pend[i]   = 1;
                    m_credit[i] = 0;
                end else if (ce) begin
                    m_credit[i]++;
                    if (m_credit[i] == PERIOD) begin
                        m_level[i] = s;
                        m_pend[i]  = 0;
                    end
                end
            end else begin
                m_pend[i] = 0;
            end
            e_level[i] = m_level[i];
            e_rise[i]  = m_level[i] && !old;
            e_fall[i]  = !m_level[i] && old;
            m_s2[i] = m_s1[i];
            m_s1[i] = sw[i];
        end
    endtask

    task automatic step(input logic [CH-1:0] sw, input logic ce, input string name);
        sw_amisha = sw;
        ce_amisha = ce;
        @(posedge clk_amisha);
        model_edge(sw, ce);
        #1;
        check(name, {db_level_amisha, rise_tick_amisha, fall_tick_amisha, long_tick_amisha},
              {e_level, e_rise, e_fall, e_long});
    endtask

    task automatic do_reset();
        reset_amisha = 1'b1;
        model_reset();
        #1;
        check("reset_outputs", {db_level_amisha, rise_tick_amisha, fall_tick_amisha, long_tick_amisha}, 32'd0);
        @(posedge clk_amisha);
        #2;
        reset_amisha = 1'b0;
    endtask

    task automatic settle_low();
        for (int j = 0; j < 12; j++) step(2'b00, 1'b1, "model_settle");
    endtask

    initial begin
        // Latency 2^N+1 edges from the first sampling edge: rise at row 9, fall at row 21.
        for (int j = 0; j < 24; j++) begin
            tbl[j].sw   = (j < 12) ? 2'b01 : 2'b00;
            tbl[j].lvl  = (j >= 9 && j < 21) ? 2'b01 : 2'b00;
            tbl[j].rise = (j == 9) ? 2'b01 : 2'b00;
            tbl[j].fall = (j == 21) ? 2'b01 : 2'b00;
        end

        #1;
        do_reset();

        for (int j = 0; j < 24; j++) begin
            step(tbl[j].sw, 1'b1, "model_tbl");
            check("tbl_level", db_level_amisha, tbl[j].lvl);
            check("tbl_ticks", {rise_tick_amisha, fall_tick_amisha}, {tbl[j].rise, tbl[j].fall});
        end

        // One-cycle low restarts the full period.
        for (int j = 0; j < 5; j++) step(2'b01, 1'b1, "model_glitch");
        step(2'b00, 1'b1, "model_glitch");
        for (int j = 0; j < 10; j++) begin
            step(2'b01, 1'b1, "model_glitch");
            check("glitch_rise", rise_tick_amisha, (j == 9) ? 2'b01 : 2'b00);
        end
        settle_low();

        // Both channels released together.
        for (int j = 0; j < 10; j++) step(2'b11, 1'b1, "model_both");
        check("both_level_high", db_level_amisha, 2'b11);
        for (int j = 0; j < 11; j++) begin
            step(2'b00, 1'b1, "model_both");
            if (j == 9) check("both_fall", fall_tick_amisha, 2'b11);
            if (j == 10) check("both_fall_once", {db_level_amisha, fall_tick_amisha}, 4'b0000);
        end

        // ce every second cycle.
        for (int j = 0; j < 18; j++) begin
            step(2'b01, (j % 2 == 0), "model_ce");
            check("ce_rise", rise_tick_amisha, (j == 16) ? 2'b01 : 2'b00);
        end
        settle_low();

        // Glitch sampled while ce is low still aborts.
        for (int j = 0; j < 24; j++) begin
            step((j == 5) ? 2'b00 : 2'b01, (j % 2 == 0), "model_ce_glitch");
            check("ce_glitch_rise", rise_tick_amisha, (j == 22) ? 2'b01 : 2'b00);
            if (j == 16) check("ce_glitch_level", db_level_amisha, 2'b00);
        end
        settle_low();

        // Reset in the middle of WAIT1 with the input held high.
        for (int j = 0; j < 5; j++) step(2'b01, 1'b1, "model_rst");
        do_reset();
        for (int j = 0; j < 11; j++) begin
            step(2'b01, 1'b1, "model_rst");
            check("rst_rise", rise_tick_amisha, (j == 9) ? 2'b01 : 2'b00);
        end
        settle_low();

`ifdef DEBOUNCE_LONGPRESS_EN
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 40; j++) begin
                step(2'b01, 1'b1, "model_long");
                check("long_tick", long_tick_amisha, (j == 24) ? 2'b01 : 2'b00);
            end
            settle_low();
        end
`endif

        // Random run against the model.
        begin
            logic [CH-1:0] sw_r;
            sw_r = '0;
            for (int j = 0; j < 4000; j++) begin
                for (int i = 0; i < CH; i++)
                    if ($urandom_range(0, 15) == 0) sw_r[i] = ~sw_r[i];
                if ($urandom_range(0, 499) == 0) do_reset();
                step(sw_r, ($urandom_range(0, 3) != 0), "model_rand");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/debounce_bank_amisha.md
# debounce_bank_amisha

Parametrised multi-channel switch/button debouncer: each of CH_AMISHA independent channels synchronises a raw mechanical input, filters bounce with a per-channel down-counter FSM, and produces a clean level plus one-cycle rise/fall ticks. It sits between board-level switch/button pins and the FSMD control logic, replacing per-pin single-channel debouncers. An optional compiled-in long-press detector flags inputs held beyond a second, longer threshold.

## Interface
- CH_AMISHA, 4, number of independent channels (1..32)
- N_AMISHA, 21, debounce counter width; stable period is 2^N_AMISHA − 1 qualifying cycles
- L_AMISHA, 24, long-press counter width (used only with DEBOUNCE_LONGPRESS_EN)
- clk_amisha  in  1  system clock, all logic on rising edge
- reset_amisha  in  1  asynchronous, active-high reset
- ce_amisha  in  1  count enable; counters advance only when high (tie 1 for per-clock counting)
- sw_amisha  in  CH_AMISHA  raw asynchronous switch inputs, bit i = channel i
- db_level_amisha  out  CH_AMISHA  debounced level, registered
- rise_tick_amisha  out  CH_AMISHA  one-cycle pulse on debounced 0→1, registered
- fall_tick_amisha  out  CH_AMISHA  one-cycle pulse on debounced 1→0, registered
- long_tick_amisha  out  CH_AMISHA  one-cycle long-press pulse; constant 0 when feature compiled out

## Operation
- Per channel: 2-FF synchroniser on sw_amisha[i] → s[i]; FSM and counters see only s[i].
- States: ZERO, WAIT1, ONE, WAIT0; reset state ZERO, counter 0.
- ZERO: s=1 → WAIT1, load q = all-ones.
- WAIT1: s=0 → ZERO (abort, no tick). s=1 and ce=1 → q−1; if q−1 == 0 → ONE. s=1, ce=0 → hold.
- ONE: s=0 → WAIT0, load q = all-ones.
- WAIT0: s=1 → ONE (abort, no tick). s=0 and ce=1 → q−1; if q−1 == 0 → ZERO. s=0, ce=0 → hold.
- Glitch abort evaluated every clock regardless of ce.
- db_level = 1 in ONE and WAIT0, 0 in ZERO and WAIT1 (registered, reflects next-state).
- rise_tick high for exactly the cycle db_level first reads 1; fall_tick likewise for first 0.
- Counter arithmetic N_AMISHA-bit unsigned; never decremented below 0, never wraps.
- Channels fully independent; simultaneous events on different channels produce simultaneous ticks.

## Timing
- Reset: all outputs 0, all FSMs ZERO, synchronisers 0, counters 0.
- Latency (ce=1): sw stable high from sampling edge k → db_level and rise_tick high after edge k + 2^N_AMISHA + 1; fall symmetric.
- With ce duty-cycled, qualifying period is 2^N_AMISHA − 1 ce-high cycles after entering WAIT.
- Any low sample of s in WAIT1 restarts the full period on next high; no partial credit.
- Reset mid-WAIT discards progress; input held high through reset release debounces afresh with full latency and a rise_tick.
- Ticks never repeat while level is steady; rise and fall never coincide on one channel.

## Configuration
- DEBOUNCE_LONGPRESS_EN defined: per-channel L_AMISHA-bit up-counter, cleared on any cycle not in ONE; in ONE with ce=1 increments, saturating at all-ones; long_tick pulses once, in the cycle the counter reaches all-ones. Leaving ONE re-arms it.
- Undefined: no long-press counters synthesised; long_tick_amisha tied to 0; all other behaviour identical.

## Test plan
- N=3, CH=2, ce=1: reset, ch0 sw 0→1 at edge k held → db_level[0] and rise_tick[0] high after edge k+9, tick width 1; ch1 remains 0.
- N=3: sw high 5 cycles, low 1, high again → no tick until 9 cycles after the second rise edge.
- N=3, ce high every 2nd cycle: steady high → level rises after 7 ce-high cycles past WAIT1 entry; glitch during ce=0 still aborts.
- N=3: both channels released simultaneously from ONE → fall_tick = 2'b11 same cycle, db_level = 0 thereafter.
- Assert reset mid-WAIT1 with sw held high → outputs 0 immediately; after release, rise_tick after full 2^N+1 edges.
- DEBOUNCE_LONGPRESS_EN, N=3, L=4: hold high → long_tick single pulse 15 cycles after entering ONE; no repeat; release and re-press → fires again.
